qmult_seq: RTL and testbench

//  Iterative signed fixed-point multiplier: the inverse operation of the sequential Qm.n divider, sharing its operand format.

---
 rtl/qmult_seq.sv | 112 +++++++++++
 tb/tb_qmult_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/qmult_seq.sv
// Sequential sign-magnitude Qm.n multiplier.
// One shift-add step per clock with a start/complete/overflow handshake.
module qmult_seq #(
    parameter int Q           = 15,
    parameter int N           = 20,
    parameter int DONE_CYCLES = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    input  logic         i_start,
    output logic [N-1:0] o_result,
    output logic         o_complete,
    output logic         o_overflow,
    output logic         o_busy
);

    localparam int AW = 2*N - 2;
    localparam int CW = $clog2(N);
    localparam int DW = $clog2(DONE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-2:0]   mag_a;
    logic [N-2:0]   mag_b;
    logic           sign;
    logic [AW-1:0]  acc;
    logic [CW-1:0]  cnt;
    logic [DW-1:0]  dcnt;
    logic [AW-1:0]  addend;
    logic           prod_ovf;
    logic [N-2:0]   prod_mag;
    logic           last_cnt;

    assign addend   = {{(N-1){1'b0}}, mag_a} << cnt;
    // Steps run while cnt is 0..N-2; cnt == N-1 is the result-forming cycle
    assign last_cnt = (cnt == CW'(N-1));
    assign prod_ovf = (acc >> (N-1+Q)) != '0;
    assign prod_mag = prod_ovf ? '1 : (N-1)'(acc >> Q);

    always_comb begin
        state_nxt  = state;
        o_complete = 1'b0;
        o_busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) state_nxt = RUN;
            end
            RUN: begin
                o_busy = 1'b1;
                if (last_cnt) state_nxt = DONE;
            end
            DONE: begin
                o_busy     = 1'b1;
                o_complete = 1'b1;
                if (dcnt == DW'(DONE_CYCLES-1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            mag_a      <= '0;
            mag_b      <= '0;
            sign       <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            dcnt       <= '0;
            o_result   <= '0;
            o_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        mag_a      <= i_multiplicand[N-2:0];
                        mag_b      <= i_multiplier[N-2:0];
                        sign       <= i_multiplicand[N-1] ^ i_multiplier[N-1];
                        acc        <= '0;
                        cnt        <= '0;
                        o_overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (!last_cnt) begin
                        if (mag_b[cnt]) acc <= acc + addend;
                        cnt <= cnt + 1'b1;
                    end else begin
                        // Zero magnitude never carries a sign
                        o_result   <= {sign & (|prod_mag), prod_mag};
                        o_overflow <= prod_ovf;
                        dcnt       <= '0;
                    end
                end
                DONE: begin
                    dcnt <= dcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qmult_seq.sv
// Scoreboard bench for qmult_seq: directed vectors, decoupled monitor.
// Checks result, overflow, latency, complete length and busy behaviour.
module tb_qmult_seq;

    localparam int N   = 20;
    localparam int LAT = 20;
    localparam int DC  = 3;

    typedef struct {
        logic [N-1:0] r;
        logic         o;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] a   = '0;
    logic [N-1:0] b   = '0;
    logic         start = 1'b0;
    logic [N-1:0] result;
    logic         complete;
    logic         overflow;
    logic         busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    qmult_seq #(.Q(15), .N(N), .DONE_CYCLES(DC)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_multiplicand (a),
        .i_multiplier   (b),
        .i_start        (start),
        .o_result       (result),
        .o_complete     (complete),
        .o_overflow     (overflow),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per rising o_complete
    logic prev = 1'b0;
    int   run_len = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (complete && !prev) begin
            run_len = 1;
            if (sb.size() == 0) begin
                chk("unexpected_complete", 1, 0);
            end else begin
                cur = sb.pop_front();
                chk("result", 32'(result), 32'(cur.r));
                chk("overflow", 32'(overflow), 32'(cur.o));
                chk("latency", cyc, cur.cyc);
            end
        end else if (complete) begin
            run_len++;
            chk("result_hold", 32'(result), 32'(cur.r));
        end else if (prev) begin
            chk("complete_len", run_len, DC);
        end
        prev = complete;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic op(input logic [N-1:0] x, input logic [N-1:0] y,
                      input logic [N-1:0] er, input logic eo);
        wait_idle();
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{er, eo, cyc + LAT});
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", 32'(result), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_complete", 32'(complete), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        op(20'h0C000, 20'h10000, 20'h18000, 1'b0);
        op(20'h8C000, 20'h10000, 20'h98000, 1'b0);
        op(20'h8C000, 20'h90000, 20'h18000, 1'b0);
        op(20'h40000, 20'h20000, 20'h7FFFF, 1'b1);
        op(20'hC0000, 20'h20000, 20'hFFFFF, 1'b1);
        op(20'h00000, 20'h98000, 20'h00000, 1'b0);
        op(20'h80001, 20'h04000, 20'h00000, 1'b0);
        op(20'h04000, 20'h04000, 20'h02000, 1'b0);
        op(20'h18000, 20'h14000, 20'h3C000, 1'b0);

        // Starts during RUN and DONE must be ignored
        op(20'h0C000, 20'h10000, 20'h18000, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 5 || k == 21) begin
                a = 20'h40000;
                b = 20'h40000;
                start = 1'b1;
                chk("busy_high", 32'(busy), 1);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        // Reset mid-RUN aborts with no completion
        wait_idle();
        @(negedge clk);
        a = 20'h18000;
        b = 20'h14000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_run", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_result", 32'(result), 0);
        chk("abort_overflow", 32'(overflow), 0);
        chk("abort_complete", 32'(complete), 0);
        chk("abort_busy", 32'(busy), 0);
        op(20'h18000, 20'h14000, 20'h3C000, 1'b0);

        // Start held high: second op accepted on first IDLE cycle
        wait_idle();
        @(negedge clk);
        a = 20'h04000;
        b = 20'h04000;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{20'h02000, 1'b0, cyc + LAT});
        sb.push_back('{20'h82000, 1'b0, cyc + LAT + DC + 1 + LAT});
        a = 20'h84000;
        repeat (LAT + DC + 1) @(posedge clk);
        #1;
        start = 1'b0;
        a = 20'h0;
        b = 20'h0;

        begin
            int n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        wait_idle();
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
